store_write_buffer: RTL
=======================

// Module: store_write_buffer
// PURPOSE
//  Post-commit store buffer between the store queue commit port and the D$ write port.
//  Accepts at most one retired store per cycle (write_en/addr/data/size) into a FIFO.
//  Drains the FIFO to D$ in order over a req/ack handshake.
//  Answers same-cycle byte-merged forwarding lookups from the load buffer, so loads see
//  committed stores that have not yet drained.
// PARAMETERS
//  WB_DEPTH  4   number of buffered stores; power of 2, >= 2
//  ADDR_W    16  byte address width (matches SQ addr)
//  DATA_W    32  store data width; fixed 32 (4 byte lanes)
// PORTS
//  clock            in   1         rising-edge clock
//  reset            in   1         asynchronous, active-high
//  write_en         in   1         SQ commit: push one store this cycle
//  write_addr       in   ADDR_W    store byte address
//  write_data       in   32        store data, low-order aligned (rs2 value)
//  write_size       in   2         0=byte 1=half 2=word (3 illegal; treated as word)
//  wb_full          out  1         count==WB_DEPTH; commit logic stalls store retire
//  wb_empty         out  1         count==0
//  wb_count         out  $clog2(WB_DEPTH)+1  current occupancy
//  overflow_err     out  1         sticky: push seen while full (push dropped)
//  dc_req           out  1         D$ write request
//  dc_addr          out  ADDR_W    head entry address
//  dc_data          out  32        head entry data (low-order aligned)
//  dc_size          out  2         head entry size
//  dc_ack           in   1         D$ accepted request this cycle
//  ld_lookup        in   1         load forwarding query valid
//  ld_addr          in   ADDR_W    load byte address
//  ld_size          in   2         load size (same encoding)
//  fwd_hit          out  1         all load bytes supplied by buffer
//  fwd_partial      out  1         some but not all load bytes covered; load must wait
//  fwd_data         out  32        forwarded bytes, load-aligned to bit 0, zero-extended
// BEHAVIOUR
//  Reset (async, any cycle incl. mid-handshake)
//   - count=0, head=tail=0, state=IDLE, all entries invalid, overflow_err=0.
//   - dc_req=0, dc_addr/data/size=0, wb_empty=1, wb_full=0.
//   - Outstanding D$ request is abandoned; a late dc_ack is ignored.
//  FIFO
//   - Push on write_en & ~wb_full at posedge; entry={addr,data,size,valid=1}; tail wraps mod WB_DEPTH.
//   - write_en & wb_full: push dropped, overflow_err<=1 (sticky until reset).
//   - Pop on dc_ack while state==REQ; head wraps.
//   - Push and pop in the same cycle: count unchanged.
//   - wb_full is from registered count only; a pop this cycle does not permit a push this cycle.
//  Drain FSM: IDLE, REQ
//   - IDLE: if count!=0 -> REQ next cycle (push-to-req latency >= 2 cycles).
//   - REQ: dc_req=1; dc_addr/data/size = head entry, held stable until dc_ack.
//   - REQ & dc_ack: pop; stay REQ if count_after_pop!=0, else -> IDLE.
//     Back-to-back drain is 1 store/cycle with dc_ack tied high.
//   - dc_req=0 in IDLE; outputs driven 0 when dc_req=0.
//  Forwarding (combinational, same cycle as ld_lookup)
//   - Byte mask: size 0 -> 1 lane at addr[1:0]; size 1 -> 2 lanes at {addr[1],0};
//     size 2/3 -> 4 lanes. Store data lane i = write_data shifted left by 8*addr[1:0].
//   - Entries match on addr[ADDR_W-1:2]; merge bytes oldest->youngest (youngest wins per lane).
//   - Visible: valid registered entries only. Entry popped this cycle is still visible;
//     entry pushed this cycle is not.
//   - cover = merged mask & load mask.
//     fwd_hit = ld_lookup & cover==load mask.
//     fwd_partial = ld_lookup & cover!=0 & ~fwd_hit.
//   - fwd_data = merged lanes shifted right by 8*ld_addr[1:0], masked to load size.
//     fwd_data=0 unless fwd_hit.
//  Arithmetic: count is $clog2(WB_DEPTH)+1 bits, never exceeds WB_DEPTH; pointers $clog2(WB_DEPTH) bits.
// TESTING
//  1. Reset mid-REQ with 3 entries -> next cycle dc_req=0, wb_count=0, wb_empty=1; later dc_ack ignored.
//  2. Push word 0x0040/0xDEADBEEF, dc_ack high -> dc_req at cycle+2 with those fields;
//     popped on ack; wb_empty=1 after.
//  3. Push 5 stores, WB_DEPTH=4, dc_ack=0 -> wb_full after 4th; 5th dropped;
//     overflow_err=1; drain order = pushes 1..4.
//  4. sw 0x11223344@0x0100 then sb 0xAA@0x0102; lw 0x0100 -> fwd_hit=1, fwd_data=0x11AA3344.
//  5. sb 0x55@0x0201; lh 0x0200 -> fwd_partial=1, fwd_hit=0.
//     lb 0x0201 -> fwd_hit=1, fwd_data=0x00000055.
//  6. Full buffer, dc_ack=1 and write_en=1 same cycle -> push dropped (full), pop proceeds, count=3.
//     Lookup to popped address still hits that cycle.

Source files
------------

// File: rtl/store_write_buffer.sv
// Post-commit store write buffer: FIFO of retired stores drained in order to the D$
// over a req/ack handshake, with same-cycle byte-merged forwarding to loads.
module store_write_buffer #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_write_en,
  input  logic [ADDR_W-1:0]           i_write_addr,
  input  logic [DATA_W-1:0]           i_write_data,
  input  logic [1:0]                  i_write_size,
  output logic                        o_wb_full,
  output logic                        o_wb_empty,
  output logic [$clog2(WB_DEPTH):0]   o_wb_count,
  output logic                        o_overflow_err,
  output logic                        o_dc_req,
  output logic [ADDR_W-1:0]           o_dc_addr,
  output logic [DATA_W-1:0]           o_dc_data,
  output logic [1:0]                  o_dc_size,
  input  logic                        i_dc_ack,
  input  logic                        i_ld_lookup,
  input  logic [ADDR_W-1:0]           i_ld_addr,
  input  logic [1:0]                  i_ld_size,
  output logic                        o_fwd_hit,
  output logic                        o_fwd_partial,
  output logic [DATA_W-1:0]           o_fwd_data
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE, S_REQ} state_t;

  // Byte lanes touched by an access; size 3 behaves as a word.
  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'd0:    byte_mask = 4'b0001 << ofs;
      2'd1:    byte_mask = ofs[1] ? 4'b1100 : 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    size_mask = 32'h0000_00FF;
      2'd1:    size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  logic [ADDR_W-1:0] r_addr [WB_DEPTH];
  logic [DATA_W-1:0] r_data [WB_DEPTH];
  logic [1:0]        r_size [WB_DEPTH];
  logic [WB_DEPTH-1:0] r_valid;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             r_dc_req;
  state_t           r_state;

  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_next;

  assign w_full       = (r_count == CNT_W'(WB_DEPTH));
  assign w_push       = i_write_en & ~w_full;
  assign w_pop        = (r_state == S_REQ) & i_dc_ack;
  assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  // NOTE: the payload array has no reset; entries are qualified by r_valid, so
  // only the valid bits and pointers need a defined reset value.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_write_addr;
      r_data[r_tail] <= i_write_data;
      r_size[r_tail] <= i_write_size;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_dc_req   <= 1'b0;
      r_state    <= S_IDLE;
    end else begin
      r_count <= w_count_next;
      if (i_write_en & w_full) r_overflow <= 1'b1;
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            r_state  <= S_REQ;
            r_dc_req <= 1'b1;
          end
        end
        S_REQ: begin
          // A push landing in the same cycle as the last pop keeps the drain going.
          if (i_dc_ack && w_count_next == '0) begin
            r_state  <= S_IDLE;
            r_dc_req <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_dc_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_wb_full      = w_full;
  assign o_wb_empty     = (r_count == '0);
  assign o_wb_count     = r_count;
  assign o_overflow_err = r_overflow;
  assign o_dc_req       = r_dc_req;
  assign o_dc_addr      = r_dc_req ? r_addr[r_head] : '0;
  assign o_dc_data      = r_dc_req ? r_data[r_head] : '0;
  assign o_dc_size      = r_dc_req ? r_size[r_head] : '0;

  logic [3:0]        w_mmask;
  logic [DATA_W-1:0] w_mlanes;
  logic [PTR_W-1:0]  w_idx;
  logic [3:0]        w_smask;
  logic [DATA_W-1:0] w_slanes;

  // Walk from head (oldest) to youngest so later stores overwrite earlier lanes.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    w_mmask  = '0;
    w_mlanes = '0;
    w_idx    = '0;
    w_smask  = '0;
    w_slanes = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_idx = r_head + PTR_W'(k);
      if (r_valid[w_idx] && r_addr[w_idx][ADDR_W-1:2] == i_ld_addr[ADDR_W-1:2]) begin
        w_smask  = byte_mask(r_size[w_idx], r_addr[w_idx][1:0]);
        w_slanes = r_data[w_idx] << {r_addr[w_idx][1:0], 3'b000};
        for (int b = 0; b < 4; b++) begin
          if (w_smask[b]) w_mlanes[8*b +: 8] = w_slanes[8*b +: 8];
        end
        w_mmask = w_mmask | w_smask;
      end
    end
  end

  logic [3:0] w_ld_mask;
  logic [3:0] w_cover;

  assign w_ld_mask     = byte_mask(i_ld_size, i_ld_addr[1:0]);
  assign w_cover       = w_mmask & w_ld_mask;
  assign o_fwd_hit     = i_ld_lookup & (w_cover == w_ld_mask);
  assign o_fwd_partial = i_ld_lookup & (w_cover != '0) & ~o_fwd_hit;
  assign o_fwd_data    = o_fwd_hit
                         ? ((w_mlanes >> {i_ld_addr[1:0], 3'b000}) & size_mask(i_ld_size))
                         : '0;

endmodule
